alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 1, ALU cycles from operand sample edge to C valid; legal range 1..4.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  request from requester 0 / 1; held high until matching done pulse.
REQ-005 op0 / op1  input  2 each  opcode of requester 0 / 1 (00 add, 01 sub, 10 ~A, 11 |B).
REQ-006 a0, b0 / a1, b1  input  4 each, signed  operands of requester 0 / 1.
REQ-007 alu_opcode  output  2  opcode driven to the shared ALU (registered).
REQ-008 alu_a, alu_b  output  4 each, signed  operands driven to the shared ALU (registered).
REQ-009 alu_c  input  5, signed  ALU result, valid ALU_LAT posedges after operands are sampled.
REQ-010 result  output  5, signed  captured ALU result, valid while done0 or done1 is high.
REQ-011 done0 / done1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states IDLE, EXEC, DONE; encoding free; only these three reachable.
REQ-014 IDLE: posedge with req0 or req1 high -> grant one, latch its op/a/b into alu_opcode/alu_a/alu_b, cnt=0, go EXEC.
REQ-015 Arbitration: one request pending -> grant it; both pending -> grant the requester not granted last (round-robin pointer last_gnt).
REQ-016 last_gnt updated on every grant; reset value 1, so req0 wins the first contention.
REQ-017 EXEC: cnt increments each posedge; at the posedge with cnt==ALU_LAT, capture alu_c into result, pulse done of granted requester, go DONE.
REQ-018 DONE: lasts exactly one cycle, done_x high and result valid for that cycle; next posedge -> IDLE, done cleared.
REQ-019 Latency (ALU_LAT=1): grant at edge t, done high in cycle after edge t+2, IDLE after edge t+3; one op per ALU_LAT+3 cycles max.
REQ-020 Requests are not sampled in EXEC or DONE; pending requests wait until IDLE.
REQ-021 alu_opcode/alu_a/alu_b hold latched values from grant until next grant; requester operand changes after grant are ignored.
REQ-022 Requester dropping req during EXEC: operation completes, done still pulses, no abort.
REQ-023 done0 and done1 never high simultaneously; done only for the granted requester.
REQ-024 result passes alu_c unmodified (no sign change or truncation); result holds its value after DONE until next capture.
REQ-025 Requester holding req high through DONE is re-arbitrated in IDLE like any new request.

Reset
REQ-026 reset high -> immediately: state IDLE, cnt 0, last_gnt 1, alu_opcode/alu_a/alu_b 0, result 0, done0/done1 0, busy 0.
REQ-027 reset mid-EXEC or mid-DONE abandons the operation; no done pulse follows reset release.
REQ-028 First grant possible at the first posedge after reset deasserts.

Verification (shared ALU connected, ALU_LAT=1)
REQ-029 req0, op0=00, a0=7, b0=7 -> grant 0, done0 pulses 3 cycles later with result=14, busy high from grant until IDLE.
REQ-030 req1, op1=01, a1=-8, b1=-8 -> done1 with result=0; op1=10, a1=0 -> result=-1 (5'b11111); op1=11, b1=4'b1000 -> result=1.
REQ-031 req0 and req1 raised same edge after reset (op 00: 1+2 and 3+4) -> done0 (result 3) first, then done1 (result 7); repeat -> order alternates.
REQ-032 req0 held continuously with req1 idle -> back-to-back grants to 0 every 4 cycles, no done1.
REQ-033 a0 changed from 7 to 1 one cycle after grant (op 00, b0=7) -> result still 14.
REQ-034 reset asserted during EXEC -> all outputs 0 at once, no done pulse; new req0 after release served normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester and shared-ALU signal bundle for alu_arbiter.
// slave: arbiter side; master: requesters plus the shared ALU result.
interface alu_arbiter_if;
    logic              req0;
    logic              req1;
    logic [1:0]        op0;
    logic [1:0]        op1;
    logic signed [3:0] a0;
    logic signed [3:0] b0;
    logic signed [3:0] a1;
    logic signed [3:0] b1;
    logic [1:0]        alu_opcode;
    logic signed [3:0] alu_a;
    logic signed [3:0] alu_b;
    logic signed [4:0] alu_c;
    logic signed [4:0] result;
    logic              done0;
    logic              done1;
    logic              busy;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_c,
        output alu_opcode, alu_a, alu_b, result, done0, done1, busy
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_c,
        input  alu_opcode, alu_a, alu_b, result, done0, done1, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared ALU,
// holding the latched operands for ALU_LAT cycles and returning the result.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] LAT = 3'(ALU_LAT);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_q, gnt_d;
    logic [1:0]        opc_q, opc_d;
    logic signed [3:0] a_q, a_d;
    logic signed [3:0] b_q, b_d;
    logic signed [4:0] res_q, res_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              pick;

    // Requester 1 wins if alone, or on contention when 0 was served last.
    assign pick = bus.req1 & (~bus.req0 | ~last_gnt_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        opc_d      = opc_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    opc_d      = pick ? bus.op1 : bus.op0;
                    a_d        = pick ? bus.a1  : bus.a0;
                    b_d        = pick ? bus.b1  : bus.b0;
                    cnt_d      = '0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAT) begin
                    res_d   = bus.alu_c;
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            opc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            opc_q      <= opc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
        end
    end

    assign bus.alu_opcode = opc_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.result     = res_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a registered shared-ALU model attached.
module tb_alu_arbiter;

    localparam int unsigned L = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter #(.ALU_LAT(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int id;
        int res;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_gnt = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU: result appears L posedges after the operands are sampled.
    function automatic logic signed [4:0] alu_f(logic [1:0] op, logic signed [3:0] a, logic signed [3:0] b);
        case (op)
            2'b00:   return {a[3], a} + {b[3], b};
            2'b01:   return {a[3], a} - {b[3], b};
            2'b10:   return ~{a[3], a};
            default: return {4'b0000, |b};
        endcase
    endfunction

    logic signed [4:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);
        for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
    end
    assign bus.alu_c = pipe[L-1];

    function automatic int ref_alu(int op, int a, int b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return -a - 1;
            default: return (b != 0) ? 1 : 0;
        endcase
    endfunction

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done0 || bus.done1) begin
                check("done_exclusive", int'(bus.done0 & bus.done1), 0);
                if (sbq.size() == 0) begin
                    check("sb_nonempty_on_done", sbq.size(), 1);
                end else begin
                    e = sbq.pop_front();
                    check("done_id", bus.done1 ? 1 : 0, e.id);
                    check("result", int'(bus.result), e.res);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_in_done", int'(bus.busy), 1);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_opcode", int'(bus.alu_opcode), 0);
        check("rst_alu_a", int'(bus.alu_a), 0);
        check("rst_alu_b", int'(bus.alu_b), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_done", int'({bus.done1, bus.done0}), 0);
        check("rst_busy", int'(bus.busy), 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        last_gnt = 1;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input int mask,
                           input logic [1:0] o0, input logic signed [3:0] x0, input logic signed [3:0] y0,
                           input logic [1:0] o1, input logic signed [3:0] x1, input logic signed [3:0] y1,
                           input bit perturb, input bit drop);
        int   first, n, g, t;
        int   ids[2];
        bit   seen0, seen1;
        exp_t e;
        bus.op0 = o0; bus.a0 = x0; bus.b0 = y0;
        bus.op1 = o1; bus.a1 = x1; bus.b1 = y1;
        bus.req0 = mask[0];
        bus.req1 = mask[1];
        g = cyc + 1;
        if (mask == 3) begin
            first = (last_gnt == 1) ? 0 : 1;
            n = 2;
        end else begin
            first = (mask == 2) ? 1 : 0;
            n = 1;
        end
        ids[0] = first;
        ids[1] = 1 - first;
        for (int k = 0; k < n; k++) begin
            e.id  = ids[k];
            e.res = (ids[k] == 0) ? ref_alu(o0, x0, y0) : ref_alu(o1, x1, y1);
            e.cyc = g + k * int'(L + 3) + int'(L) + 1;
            sbq.push_back(e);
        end
        last_gnt = ids[n-1];
        seen0 = (mask[0] == 1'b0);
        seen1 = (mask[1] == 1'b0);
        for (t = 0; t < 40 && !(seen0 && seen1); t++) begin
            @(negedge clk);
            if (t == 0) begin
                check("busy_after_grant", int'(bus.busy), 1);
                if (perturb) begin
                    if (first == 0) begin bus.a0 = bus.a0 ^ 4'sb0110; bus.b0 = bus.b0 ^ 4'sb0101; bus.op0 = bus.op0 ^ 2'b01; end
                    else            begin bus.a1 = bus.a1 ^ 4'sb0110; bus.b1 = bus.b1 ^ 4'sb0101; bus.op1 = bus.op1 ^ 2'b01; end
                end
            end
            if (t == 1 && drop) begin
                if (first == 0) bus.req0 = 1'b0;
                else            bus.req1 = 1'b0;
            end
            if (bus.done0) begin bus.req0 = 1'b0; seen0 = 1'b1; end
            if (bus.done1) begin bus.req1 = 1'b0; seen1 = 1'b1; end
        end
        check("txn_completed", int'(seen0 && seen1), 1);
        @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);
    endtask

    // req0 held high across several operations; new operands presented after each done.
    task automatic hold0(input int n);
        logic [1:0]        ops[4];
        logic signed [3:0] as[4];
        logic signed [3:0] bs[4];
        int                g, got;
        exp_t              e;
        for (int k = 0; k < n; k++) begin
            ops[k] = 2'($urandom);
            as[k]  = 4'($urandom);
            bs[k]  = 4'($urandom);
        end
        bus.op0 = ops[0]; bus.a0 = as[0]; bus.b0 = bs[0];
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        g = cyc + 1;
        for (int k = 0; k < n; k++) begin
            e.id  = 0;
            e.res = ref_alu(ops[k], as[k], bs[k]);
            e.cyc = g + k * int'(L + 3) + int'(L) + 1;
            sbq.push_back(e);
        end
        last_gnt = 0;
        got = 0;
        for (int t = 0; t < 80 && got < n; t++) begin
            @(negedge clk);
            if (bus.done0) begin
                got++;
                if (got < n) begin
                    bus.op0 = ops[got]; bus.a0 = as[got]; bus.b0 = bs[got];
                end else begin
                    bus.req0 = 1'b0;
                end
            end
        end
        check("hold_completed", got, n);
        @(negedge clk);
        check("hold_idle_busy", int'(bus.busy), 0);
    endtask

    initial begin : stim
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
        bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;
        reset = 1'b0;
        #2;
        do_reset();

        run_txn(1, 2'b00, 4'sd7, 4'sd7, 2'b00, 4'sd0, 4'sd0, 1'b0, 1'b0);
        run_txn(2, 2'b00, 4'sd0, 4'sd0, 2'b01, -4'sd8, -4'sd8, 1'b0, 1'b0);
        run_txn(2, 2'b00, 4'sd0, 4'sd0, 2'b10, 4'sd0, 4'sd0, 1'b0, 1'b0);
        run_txn(2, 2'b00, 4'sd0, 4'sd0, 2'b11, 4'sd0, -4'sd8, 1'b0, 1'b0);
        run_txn(1, 2'b00, 4'sd7, 4'sd7, 2'b00, 4'sd0, 4'sd0, 1'b1, 1'b0);

        do_reset();
        run_txn(3, 2'b00, 4'sd1, 4'sd2, 2'b00, 4'sd3, 4'sd4, 1'b0, 1'b0);
        run_txn(3, 2'b00, 4'sd1, 4'sd2, 2'b00, 4'sd3, 4'sd4, 1'b0, 1'b0);
        run_txn(1, 2'b00, 4'sd3, 4'sd2, 2'b00, 4'sd0, 4'sd0, 1'b0, 1'b0);
        run_txn(3, 2'b00, -4'sd5, 4'sd2, 2'b01, 4'sd6, -4'sd3, 1'b0, 1'b0);

        hold0(3);
        run_txn(1, 2'b01, 4'sd3, -4'sd2, 2'b00, 4'sd0, 4'sd0, 1'b0, 1'b1);

        // Abandon an operation mid-EXEC; the monitor flags any stray done.
        bus.op0 = 2'b01; bus.a0 = 4'sd5; bus.b0 = 4'sd3;
        bus.req0 = 1'b1;
        @(negedge clk);
        check("pre_reset_busy", int'(bus.busy), 1);
        bus.req0 = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        run_txn(1, 2'b00, 4'sd2, 4'sd5, 2'b00, 4'sd0, 4'sd0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            run_txn(int'($urandom_range(1, 3)),
                    2'($urandom), 4'($urandom), 4'($urandom),
                    2'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
